pe_stream_core: RTL and testbench

Parametrised successor processing element for the convolution datapath. It holds a FILT_LEN-tap filter and consumes window samples over a valid/ready stream. For each window it produces a requantised, saturated MAC result. It packs LANES results into one output word and writes that word to an auto-incrementing address through a valid/ready handshake, with signed/unsigned mode and a stop/flush feature.

---
 rtl/pe_pkg.sv | 38 +++
 rtl/pe_mac_requant.sv | 51 +++++
 rtl/pe_stream_core.sv | 164 ++++++++++++++++
 tb/tb_pe_stream_core.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// pe_pkg: state encoding and shared helpers for the PE stream core.
// Revision: 1.0
package pe_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_NORM = 2'd2,
    S_OUT  = 2'd3
  } pe_state_t;

  localparam int SAT_W = 64;

  // The lane counter must be able to hold LANES itself, not just LANES-1.
  function automatic int lane_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  function automatic logic [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] val,
                                                input int data_w,
                                                input logic is_signed);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    if (is_signed) begin
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
    end else begin
      hi = (64'sd1 <<< data_w) - 64'sd1;
      lo = 64'sd0;
    end
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac_requant.sv
`default_nettype none
// pe_mac_requant: wrapping MAC accumulator with shift and saturating requantisation.
// Revision: 1.0
module pe_mac_requant
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              acc_en,
  input  logic              mode_signed,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] tap,
  output logic [DATA_W-1:0] r
);

  logic [ACC_W-1:0]        r_acc;
  logic [ACC_W-1:0]        w_sample_x;
  logic [ACC_W-1:0]        w_tap_x;
  logic [ACC_W-1:0]        w_prod;
  logic signed [ACC_W-1:0] w_sra;
  logic [ACC_W-1:0]        w_srl;
  logic [SAT_W-1:0]        w_wide;

  assign w_sample_x = {{(ACC_W-DATA_W){mode_signed & sample[DATA_W-1]}}, sample};
  assign w_tap_x    = {{(ACC_W-DATA_W){mode_signed & tap[DATA_W-1]}}, tap};
  // Low ACC_W bits of the product are correct for both signed and unsigned operands.
  assign w_prod     = w_sample_x * w_tap_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (acc_en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign w_sra  = $signed(r_acc) >>> SHIFT;
  assign w_srl  = r_acc >> SHIFT;
  assign w_wide = mode_signed ? {{(SAT_W-ACC_W){w_sra[ACC_W-1]}}, w_sra}
                              : {{(SAT_W-ACC_W){1'b0}}, w_srl};
  assign r      = DATA_W'(saturate(w_wide, DATA_W, mode_signed));

endmodule
`default_nettype wire

// File: rtl/pe_stream_core.sv
`default_nettype none
// pe_stream_core: streaming filter PE packing LANES requantised results per output word.
// Revision: 1.0
module pe_stream_core
  import pe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int FILT_LEN = 9,
  parameter int LANES    = 4,
  parameter int ADDR_W   = 8,
  parameter int SHIFT    = 0,
  localparam int GROUPS  = (FILT_LEN + LANES - 1) / LANES,
  localparam int IDX_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode_signed,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    stop,
  input  logic                    filt_wr_en,
  input  logic [IDX_W-1:0]        filt_wr_idx,
  input  logic [LANES*DATA_W-1:0] filt_wr_data,
  input  logic                    win_valid,
  output logic                    win_ready,
  input  logic [DATA_W-1:0]       win_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    busy,
  output logic                    done
);

  localparam int K_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int LANE_W = lane_cnt_w(LANES);

  pe_state_t               state;
  logic [DATA_W-1:0]       r_taps [FILT_LEN];
  logic [K_W-1:0]          r_k;
  logic [LANE_W-1:0]       r_lane;
  logic [ADDR_W-1:0]       r_addr;
  logic [LANES*DATA_W-1:0] r_pack;
  logic                    r_mode;
  logic                    r_stop_pend;
  logic                    w_accept;
  logic                    w_clear;
  logic [DATA_W-1:0]       w_r;

  assign win_ready = (state == S_ACC) && !(r_stop_pend && (r_k == '0));
  assign w_accept  = win_valid && win_ready;
  assign w_clear   = ((state == S_IDLE) && start) || (state == S_NORM);
  assign busy      = (state != S_IDLE);
  assign out_data  = r_pack;
  assign out_addr  = r_addr;

  // Lanes of the last group that fall past FILT_LEN have no tap register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < FILT_LEN; t++) r_taps[t] <= '0;
    end else if ((state == S_IDLE) && filt_wr_en) begin
      for (int t = 0; t < FILT_LEN; t++) begin
        if (filt_wr_idx == IDX_W'(t / LANES))
          r_taps[t] <= filt_wr_data[(t % LANES)*DATA_W +: DATA_W];
      end
    end
  end

  pe_mac_requant #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .clear       (w_clear),
    .acc_en      (w_accept),
    .mode_signed (r_mode),
    .sample      (win_data),
    .tap         (r_taps[r_k]),
    .r           (w_r)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      r_k         <= '0;
      r_lane      <= '0;
      r_addr      <= '0;
      r_pack      <= '0;
      r_mode      <= 1'b0;
      r_stop_pend <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_ACC;
            r_k         <= '0;
            r_lane      <= '0;
            r_addr      <= base_addr;
            r_pack      <= '0;
            r_mode      <= mode_signed;
            r_stop_pend <= 1'b0;
          end
        end
        S_ACC: begin
          r_stop_pend <= r_stop_pend | stop;
          // A pending stop only takes effect on a result boundary.
          if (r_stop_pend && (r_k == '0)) begin
            if (r_lane == '0) begin
              state       <= S_IDLE;
              done        <= 1'b1;
              r_stop_pend <= 1'b0;
            end else begin
              state     <= S_OUT;
              out_valid <= 1'b1;
            end
          end else if (w_accept) begin
            if (r_k == K_W'(FILT_LEN - 1)) begin
              r_k   <= '0;
              state <= S_NORM;
            end else begin
              r_k <= r_k + K_W'(1);
            end
          end
        end
        S_NORM: begin
          r_stop_pend                      <= r_stop_pend | stop;
          r_pack[r_lane*DATA_W +: DATA_W]  <= w_r;
          r_lane                           <= r_lane + LANE_W'(1);
          if (r_lane == LANE_W'(LANES - 1)) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
          end else begin
            state <= S_ACC;
          end
        end
        S_OUT: begin
          r_stop_pend <= r_stop_pend | stop;
          if (out_ready) begin
            out_valid <= 1'b0;
            r_addr    <= r_addr + ADDR_W'(1);
            r_pack    <= '0;
            r_lane    <= '0;
            if (r_stop_pend) begin
              state       <= S_IDLE;
              done        <= 1'b1;
              r_stop_pend <= 1'b0;
            end else begin
              state <= S_ACC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_stream_core.sv
`default_nettype none
// tb_pe_stream_core: randomized self-checking bench against an arithmetic reference model.
// Revision: 1.0
module tb_pe_stream_core;

  localparam int DW  = 8;
  localparam int AW  = 20;
  localparam int FL  = 9;
  localparam int LN  = 4;
  localparam int ADW = 8;
  localparam int SH  = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mode_signed = 1'b0;
  logic              start = 1'b0;
  logic [ADW-1:0]    base_addr = '0;
  logic              stop = 1'b0;
  logic              filt_wr_en = 1'b0;
  logic [1:0]        filt_wr_idx = '0;
  logic [LN*DW-1:0]  filt_wr_data = '0;
  logic              win_valid = 1'b0;
  logic              win_ready;
  logic [DW-1:0]     win_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LN*DW-1:0]  out_data;
  logic [ADW-1:0]    out_addr;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] taps [FL];
  logic       cur_sgn = 1'b0;
  logic       gaps = 1'b0;

  pe_stream_core #(
    .DATA_W(DW), .ACC_W(AW), .FILT_LEN(FL), .LANES(LN), .ADDR_W(ADW), .SHIFT(SH)
  ) dut (
    .clk(clk), .rst(rst), .mode_signed(mode_signed), .start(start),
    .base_addr(base_addr), .stop(stop), .filt_wr_en(filt_wr_en),
    .filt_wr_idx(filt_wr_idx), .filt_wr_data(filt_wr_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sum of products, wrapped to AW bits, shifted, then clamped to the lane range.
  function automatic logic [7:0] model_res(input logic sgn, input logic [7:0] smp [FL]);
    longint acc, a, b, lo, hi;
    acc = 0;
    for (int i = 0; i < FL; i++) begin
      if (sgn) begin
        a = longint'($signed(smp[i]));
        b = longint'($signed(taps[i]));
      end else begin
        a = longint'(smp[i]);
        b = longint'(taps[i]);
      end
      acc += a * b;
    end
    acc = acc & ((longint'(1) << AW) - 1);
    if (sgn && acc >= (longint'(1) << (AW - 1))) acc -= (longint'(1) << AW);
    acc = acc >>> SH;
    if (sgn) begin
      lo = -(longint'(1) << (DW - 1));
      hi = (longint'(1) << (DW - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << DW) - 1;
    end
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
    return acc[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_taps();
    logic [31:0] d;
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < LN; j++) begin
        if (g*LN + j < FL) d[j*8 +: 8] = taps[g*LN + j];
        else               d[j*8 +: 8] = 8'($urandom);
      end
      filt_wr_idx  = 2'(g);
      filt_wr_data = d;
      filt_wr_en   = 1'b1;
      tick();
      filt_wr_en = 1'b0;
    end
  endtask

  task automatic set_taps(input logic [7:0] v);
    for (int i = 0; i < FL; i++) taps[i] = v;
    load_taps();
  endtask

  task automatic start_run(input logic sgn, input logic [7:0] base);
    cur_sgn     = sgn;
    mode_signed = sgn;
    base_addr   = base;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    int i;
    if (gaps && $urandom_range(0, 3) == 0) begin
      win_valid = 1'b0;
      tick();
    end
    win_valid = 1'b1;
    win_data  = d;
    i = 0;
    while (!win_ready && i < 50) begin
      tick();
      i++;
    end
    if (!win_ready) check_eq("win_ready_timeout", win_ready, 1);
    tick();
    win_valid = 1'b0;
  endtask

  task automatic feed_result(input int kind, input logic [7:0] cval, output logic [7:0] res);
    logic [7:0] smp [FL];
    for (int i = 0; i < FL; i++) begin
      case (kind)
        0:       smp[i] = 8'(i + 1);
        1:       smp[i] = cval;
        default: smp[i] = 8'($urandom);
      endcase
    end
    for (int i = 0; i < FL; i++) push(smp[i]);
    res = model_res(cur_sgn, smp);
  endtask

  task automatic feed_word(input int kind, input logic [7:0] cval, output logic [31:0] exp);
    logic [7:0] res;
    for (int r = 0; r < LN; r++) begin
      feed_result(kind, cval, res);
      exp[r*8 +: 8] = res;
    end
  endtask

  task automatic get_packet(input logic [31:0] exp_data, input logic [7:0] exp_addr, input int hold);
    int i;
    logic [7:0] nxt;
    i = 0;
    while (!out_valid && i < 50) begin
      tick();
      i++;
    end
    check_eq("pkt_valid", out_valid, 1);
    check_eq("pkt_data", out_data, exp_data);
    check_eq("pkt_addr", out_addr, exp_addr);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_data", out_data, exp_data);
      check_eq("bp_addr", out_addr, exp_addr);
      check_eq("bp_win_ready", win_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    nxt = exp_addr + 8'd1;
    check_eq("pkt_released", out_valid, 0);
    check_eq("addr_next", out_addr, nxt);
  endtask

  task automatic end_run();
    int i;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    i = 0;
    while (!done && i < 20) begin
      tick();
      i++;
    end
    check_eq("end_done", done, 1);
  endtask

  initial begin
    logic [7:0]  res;
    logic [31:0] exp;
    logic [7:0]  base;
    logic        seen_valid;
    logic        seen_done;

    #12;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_win_ready", win_ready, 0);
    check_eq("rst_out_addr", out_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic run with taps of 1, ignored write outside IDLE, latency check.
    set_taps(8'd1);
    start_run(1'b0, 8'h10);
    check_eq("busy_after_start", busy, 1);
    filt_wr_idx  = 2'd0;
    filt_wr_data = '0;
    filt_wr_en   = 1'b1;
    tick();
    filt_wr_en = 1'b0;
    for (int r = 0; r < LN; r++) feed_result(0, 8'd0, res);
    check_eq("lat_norm", out_valid, 0);
    tick();
    check_eq("lat_out", out_valid, 1);
    get_packet(32'h2D2D2D2D, 8'h10, 0);
    check_eq("t1_done", done, 0);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_win_ready", win_ready, 1);

    // Backpressure for 5 cycles.
    feed_word(0, 8'd0, exp);
    get_packet(32'h2D2D2D2D, 8'h11, 5);

    // Stop after two results flushes a partial word.
    feed_result(0, 8'd0, res);
    feed_result(0, 8'd0, res);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    get_packet(32'h00002D2D, 8'h12, 0);
    check_eq("stop_done", done, 1);
    check_eq("stop_busy", busy, 0);
    tick();
    check_eq("stop_done_pulse", done, 0);

    // Stop with no pending lanes: done without out_valid.
    start_run(1'b0, 8'h40);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    seen_valid = 1'b0;
    seen_done  = 1'b0;
    for (int i = 0; i < 10 && !seen_done; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
      if (done) seen_done = 1'b1;
    end
    check_eq("stop0_done", seen_done, 1);
    check_eq("stop0_no_valid", seen_valid, 0);
    check_eq("stop0_busy", busy, 0);

    // Saturation corners.
    set_taps(8'hFF);
    start_run(1'b0, 8'h00);
    feed_word(1, 8'hFF, exp);
    get_packet(32'hFFFFFFFF, 8'h00, 0);
    end_run();
    set_taps(8'h80);
    start_run(1'b1, 8'h00);
    feed_word(1, 8'h80, exp);
    get_packet(32'h7F7F7F7F, 8'h00, 0);
    end_run();
    set_taps(8'h01);
    start_run(1'b1, 8'h00);
    feed_word(1, 8'hFF, exp);
    get_packet(32'hF7F7F7F7, 8'h00, 0);
    end_run();

    // Address wrap with random data.
    gaps = 1'b1;
    for (int i = 0; i < FL; i++) taps[i] = 8'($urandom);
    load_taps();
    start_run(1'($urandom), 8'hFE);
    base = 8'hFE;
    for (int p = 0; p < 3; p++) begin
      feed_word(2, 8'd0, exp);
      get_packet(exp, base, $urandom_range(0, 2));
      base = base + 8'd1;
    end
    end_run();

    // Randomized runs.
    for (int run = 0; run < 6; run++) begin
      for (int i = 0; i < FL; i++) taps[i] = 8'($urandom);
      load_taps();
      base = 8'($urandom);
      start_run(1'($urandom), base);
      for (int p = 0; p < 2; p++) begin
        feed_word(2, 8'd0, exp);
        get_packet(exp, base, $urandom_range(0, 3));
        base = base + 8'd1;
      end
      end_run();
    end
    gaps = 1'b0;

    // Reset in the middle of the second result.
    set_taps(8'd1);
    start_run(1'b0, 8'h10);
    feed_result(0, 8'd0, res);
    for (int i = 0; i < 4; i++) push(8'(i + 1));
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_out_data", out_data, 0);
    check_eq("arst_out_addr", out_addr, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_win_ready", win_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    load_taps();
    start_run(1'b0, 8'h10);
    feed_word(0, 8'd0, exp);
    get_packet(32'h2D2D2D2D, 8'h10, 0);
    end_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before the bench completed");
    $fatal(1);
  end

endmodule
`default_nettype wire
